ram_window_addr_gen: RTL and testbench
======================================

# ram_window_addr_gen

Generates the RAM read address sequence for one K×K convolution window, starting at the lower limit produced by the upstream offset adder. Addresses are issued row-major over a configurable image row stride through a valid/ready handshake to the RAM read port. When the window is finished, the block pulses `Sum_En` so the offset adder advances the lower limit for the next window.

## Interface
- `BITWIDTH`, 10: address width; also the width of the lower limit and the row stride.
- `KBITS`, 3: width of `Kernel_Size`; K ranges 0..2^KBITS-1.
- `RAM_WINDOW_ADDR_GEN_clk`  in  1  clock; all logic on the rising edge.
- `RAM_WINDOW_ADDR_GEN_Reset`  in  1  reset; synchronous, active-high.
- `RAM_WINDOW_ADDR_GEN_Start`  in  1  one-cycle request to start a window; sampled only in IDLE.
- `RAM_WINDOW_ADDR_GEN_Lower_Limit`  in  BITWIDTH  window base address, from the offset adder.
- `RAM_WINDOW_ADDR_GEN_Img_Width`  in  BITWIDTH  row stride in words.
- `RAM_WINDOW_ADDR_GEN_Kernel_Size`  in  KBITS  K.
- `RAM_WINDOW_ADDR_GEN_Ready`  in  1  downstream accepts the current address.
- `RAM_WINDOW_ADDR_GEN_Addr`  out  BITWIDTH  read address.
- `RAM_WINDOW_ADDR_GEN_Valid`  out  1  `Addr` is valid.
- `RAM_WINDOW_ADDR_GEN_Last`  out  1  marks the final address of the window.
- `RAM_WINDOW_ADDR_GEN_Busy`  out  1  high in RUN.
- `RAM_WINDOW_ADDR_GEN_Done`  out  1  one-cycle pulse when the window completes.
- `RAM_WINDOW_ADDR_GEN_Sum_En`  out  1  one-cycle pulse to the offset adder; coincident with `Done`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `Start` with K≠0. `Lower_Limit`, `Img_Width` and K are latched; `row_base`=Lower_Limit; `row`=`col`=0.
  - IDLE→DONE on `Start` with K=0. No addresses are issued.
  - RUN→DONE on the handshake (`Valid`&`Ready`) of the `Last` address.
  - DONE→IDLE unconditionally after one cycle.
- `Addr` = `row_base` + `col`, computed modulo 2^BITWIDTH. Wrap-around is silent.
- On each handshake:
  - If `col`<K-1: `col`++.
  - Otherwise: `col`=0, `row`++, `row_base` += latched width (mod 2^BITWIDTH).
- `Last` = (`row`==K-1)&(`col`==K-1) while in RUN.
- Exactly K² handshakes occur per window.
- The block uses only its latched copies of `Lower_Limit`, `Img_Width` and K during RUN, so input changes mid-window have no effect.
- `Start` is ignored in RUN and DONE. It is not queued.
- Reset outputs: `Addr`=0, `Valid`=0, `Last`=0, `Busy`=0, `Done`=0, `Sum_En`=0. State returns to IDLE.

## Timing
- `Start` is sampled at edge t. `Valid` rises after edge t; the first address is presented in cycle t+1.
- With `Ready` held high, one address is issued per cycle. The final address is in cycle t+K².
- While `Valid`&!`Ready`, `Addr` and `Last` hold stable and `Valid` stays high. `Valid` never drops without a handshake.
- `Done` and `Sum_En` are high for exactly the one cycle after the final handshake, with `Valid`=0 in that cycle. The earliest next `Start` is accepted in the cycle after `Done`.
- K=0: `Done` and `Sum_En` pulse in cycle t+1.
- Reset asserted mid-window aborts the window on the next edge. No `Done` or `Sum_En` pulse is produced.
- If reset and `Start` are asserted together, reset wins.

## Configuration
- The stall counter is controlled by the macro `RAM_WINDOW_ADDR_GEN_STALL_CNT_EN`.
- Defined:
  - Adds output `RAM_WINDOW_ADDR_GEN_Stall_Count` [15:0].
  - Counts cycles with `Valid`&!`Ready`, saturating at 0xFFFF.
  - Cleared by reset and on each accepted `Start`.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default `BITWIDTH` and `KBITS` values, shared with the offset adder.
- One sub-module, `ram_window_addr_gen_cnt`:
  - Contains the row/col counters and the `row_base` accumulator.
  - Takes `step` (=handshake), `load`, K and width.
  - Returns `Addr` and `Last`.
- The FSM and handshake logic live in the top.

## Test plan
- Basic window: BITWIDTH=10, Lower_Limit=5, width=28, K=3, `Ready`=1 → addresses 5,6,7,33,34,35,61,62,63; `Last` on 63; `Done`/`Sum_En` pulse the next cycle.
- Address wrap: Lower_Limit=1020, width=28, K=2 → addresses 1020,1021,24,25.
- Backpressure: as in the basic window, with `Ready`=0 for 3 cycles while `Addr`=33 → 33 is held for 4 cycles, the sequence is unchanged, and `Stall_Count`=3 when the macro is defined.
- K=0 and Start while busy:
  - `Start` with K=0 → no `Valid`; `Done`+`Sum_En` in cycle t+1.
  - `Start` pulsed during RUN → ignored; exactly K² addresses are issued.
- Reset mid-window: assert reset after the 4th handshake → next cycle all outputs are 0 and the state is IDLE, with no `Done`; a new `Start` then runs a full window from its new Lower_Limit.

Source files
------------

// File: rtl/ram_window_addr_gen_pkg.sv
// Shared definitions for the RAM window address generator.
// Holds the FSM state encoding and the default address and kernel widths.
// The offset adder uses the same default widths.
package ram_window_addr_gen_pkg;

  localparam int DEF_BITWIDTH = 10;
  localparam int DEF_KBITS    = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/ram_window_addr_gen_cnt.sv
// Row/column walker for one KxK window.
// On load_i it captures the window base, the row stride and K.
// On each step_i it advances row-major through the window.
//   clk_i, rst_i : clock and synchronous active-high reset
//   load_i       : capture base_i / width_i / k_i and restart at row 0, col 0
//   step_i       : advance by one address (an accepted handshake)
//   addr_o       : row_base + col (mod 2^BITWIDTH)
//   last_o       : current position is (K-1, K-1)
module ram_window_addr_gen_cnt
  import ram_window_addr_gen_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int KBITS    = DEF_KBITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [BITWIDTH-1:0] base_i,
  input  logic [BITWIDTH-1:0] width_i,
  input  logic [KBITS-1:0]    k_i,
  output logic [BITWIDTH-1:0] addr_o,
  output logic                last_o
);

  logic [BITWIDTH-1:0] row_base_q, row_base_d;
  logic [BITWIDTH-1:0] width_q, width_d;
  logic [KBITS-1:0]    k_q, k_d;
  logic [KBITS-1:0]    row_q, row_d;
  logic [KBITS-1:0]    col_q, col_d;
  logic [KBITS-1:0]    k_m1;

  assign k_m1 = k_q - KBITS'(1);

  always_comb begin
    row_base_d = row_base_q;
    width_d    = width_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    if (load_i) begin
      row_base_d = base_i;
      width_d    = width_i;
      k_d        = k_i;
      row_d      = '0;
      col_d      = '0;
    end else if (step_i) begin
      if (col_q != k_m1) begin
        col_d = col_q + KBITS'(1);
      end else begin
        // End of a row: jump the base down one image row.
        col_d      = '0;
        row_d      = row_q + KBITS'(1);
        row_base_d = row_base_q + width_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_base_q <= '0;
      width_q    <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      width_q    <= width_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  // Wrap-around past 2^BITWIDTH is intentional and silent.
  assign addr_o = row_base_q + BITWIDTH'(col_q);
  assign last_o = (row_q == k_m1) && (col_q == k_m1);

endmodule

// File: rtl/ram_window_addr_gen.sv
// RAM read address generator for one KxK convolution window.
// Issues K*K addresses row-major from Lower_Limit over a valid/ready port.
// When the window is finished it pulses Done/Sum_En so the offset adder
// advances to the next window.
// Ports (prefix RAM_WINDOW_ADDR_GEN_):
//   clk, Reset (sync, active-high), Start, Lower_Limit, Img_Width, Kernel_Size,
//   Ready  -> Addr, Valid, Last, Busy, Done, Sum_En
//   Stall_Count [15:0] (only with RAM_WINDOW_ADDR_GEN_STALL_CNT_EN defined):
//   counts cycles with Valid & !Ready and saturates at 0xFFFF.
module ram_window_addr_gen
  import ram_window_addr_gen_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int KBITS    = DEF_KBITS
) (
  input  logic                RAM_WINDOW_ADDR_GEN_clk,
  input  logic                RAM_WINDOW_ADDR_GEN_Reset,
  input  logic                RAM_WINDOW_ADDR_GEN_Start,
  input  logic [BITWIDTH-1:0] RAM_WINDOW_ADDR_GEN_Lower_Limit,
  input  logic [BITWIDTH-1:0] RAM_WINDOW_ADDR_GEN_Img_Width,
  input  logic [KBITS-1:0]    RAM_WINDOW_ADDR_GEN_Kernel_Size,
  input  logic                RAM_WINDOW_ADDR_GEN_Ready,
  output logic [BITWIDTH-1:0] RAM_WINDOW_ADDR_GEN_Addr,
  output logic                RAM_WINDOW_ADDR_GEN_Valid,
  output logic                RAM_WINDOW_ADDR_GEN_Last,
  output logic                RAM_WINDOW_ADDR_GEN_Busy,
  output logic                RAM_WINDOW_ADDR_GEN_Done,
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
  output logic [15:0]         RAM_WINDOW_ADDR_GEN_Stall_Count,
`endif
  output logic                RAM_WINDOW_ADDR_GEN_Sum_En
);

  state_e state_q, state_d;
  logic   start_acc;
  logic   load;
  logic   step;
  logic   cnt_last;

  // Start only counts in IDLE; in RUN and DONE it is dropped, not queued.
  assign start_acc = (state_q == IDLE) && RAM_WINDOW_ADDR_GEN_Start;
  assign load      = start_acc && (RAM_WINDOW_ADDR_GEN_Kernel_Size != '0);
  assign step      = RAM_WINDOW_ADDR_GEN_Valid && RAM_WINDOW_ADDR_GEN_Ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (RAM_WINDOW_ADDR_GEN_Start) begin
          state_d = (RAM_WINDOW_ADDR_GEN_Kernel_Size != '0) ? RUN : DONE;
        end
      end
      RUN:     if (step && cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RAM_WINDOW_ADDR_GEN_clk) begin
    if (RAM_WINDOW_ADDR_GEN_Reset) state_q <= IDLE;
    else                           state_q <= state_d;
  end

  ram_window_addr_gen_cnt #(
    .BITWIDTH (BITWIDTH),
    .KBITS    (KBITS)
  ) u_cnt (
    .clk_i   (RAM_WINDOW_ADDR_GEN_clk),
    .rst_i   (RAM_WINDOW_ADDR_GEN_Reset),
    .load_i  (load),
    .step_i  (step),
    .base_i  (RAM_WINDOW_ADDR_GEN_Lower_Limit),
    .width_i (RAM_WINDOW_ADDR_GEN_Img_Width),
    .k_i     (RAM_WINDOW_ADDR_GEN_Kernel_Size),
    .addr_o  (RAM_WINDOW_ADDR_GEN_Addr),
    .last_o  (cnt_last)
  );

  // All handshake outputs are decoded from state, so Addr/Last hold while stalled.
  assign RAM_WINDOW_ADDR_GEN_Valid  = (state_q == RUN);
  assign RAM_WINDOW_ADDR_GEN_Busy   = (state_q == RUN);
  assign RAM_WINDOW_ADDR_GEN_Last   = (state_q == RUN) && cnt_last;
  assign RAM_WINDOW_ADDR_GEN_Done   = (state_q == DONE);
  assign RAM_WINDOW_ADDR_GEN_Sum_En = (state_q == DONE);

`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (RAM_WINDOW_ADDR_GEN_Valid && !RAM_WINDOW_ADDR_GEN_Ready &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge RAM_WINDOW_ADDR_GEN_clk) begin
    if (RAM_WINDOW_ADDR_GEN_Reset) stall_q <= '0;
    else                           stall_q <= stall_d;
  end

  assign RAM_WINDOW_ADDR_GEN_Stall_Count = stall_q;
`endif

endmodule

// File: tb/tb_ram_window_addr_gen.sv
// Self-checking bench for ram_window_addr_gen. Expected addresses come from
// base + row*width + col (mod 1024) held in a queue.
module tb_ram_window_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  ll;
  logic [9:0]  wid;
  logic [2:0]  ks;
  logic        rdy;
  logic [9:0]  addr;
  logic        valid, last, busy, done, sum_en;
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_window_addr_gen dut (
    .RAM_WINDOW_ADDR_GEN_clk         (clk),
    .RAM_WINDOW_ADDR_GEN_Reset       (rst),
    .RAM_WINDOW_ADDR_GEN_Start       (start),
    .RAM_WINDOW_ADDR_GEN_Lower_Limit (ll),
    .RAM_WINDOW_ADDR_GEN_Img_Width   (wid),
    .RAM_WINDOW_ADDR_GEN_Kernel_Size (ks),
    .RAM_WINDOW_ADDR_GEN_Ready       (rdy),
    .RAM_WINDOW_ADDR_GEN_Addr        (addr),
    .RAM_WINDOW_ADDR_GEN_Valid       (valid),
    .RAM_WINDOW_ADDR_GEN_Last        (last),
    .RAM_WINDOW_ADDR_GEN_Busy        (busy),
    .RAM_WINDOW_ADDR_GEN_Done        (done),
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
    .RAM_WINDOW_ADDR_GEN_Stall_Count (stall_cnt),
`endif
    .RAM_WINDOW_ADDR_GEN_Sum_En      (sum_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".valid"}, 32'(valid), 0);
    chk({tag, ".busy"},  32'(busy),  0);
    chk({tag, ".last"},  32'(last),  0);
    chk({tag, ".done"},  32'(done),  0);
    chk({tag, ".sumen"}, 32'(sum_en), 0);
  endtask

  // mode 0: Ready always high
  // mode 1: random Ready, random Start pulses and input scrambling mid-window
  // mode 2: Ready low for 3 cycles while the 4th address is presented
  // abort_after > 0: assert reset after that many handshakes
  task automatic run_window(input int base, input int w, input int k,
                            input int mode, input int abort_after);
    int q[$];
    int pops = 0;
    int stalls = 0;
    int bp_left = 3;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        q.push_back((base + r * w + c) % 1024);

    @(negedge clk);
    start = 1'b1; ll = 10'(base); wid = 10'(w); ks = 3'(k); rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (k == 0) begin
      chk("k0.valid", 32'(valid), 0);
      chk("k0.done",  32'(done),  1);
      chk("k0.sumen", 32'(sum_en), 1);
      @(negedge clk);
      chk_idle_outs("k0.after");
      return;
    end

    for (int cyc = 0; cyc < 300 && q.size() > 0; cyc++) begin
      if (abort_after > 0 && pops == abort_after) break;
      case (mode)
        1: begin
          rdy   = ($urandom_range(0, 3) != 0);
          start = 1'($urandom_range(0, 1));
          ll    = 10'($urandom);
          wid   = 10'($urandom);
          ks    = 3'($urandom);
        end
        2: begin
          rdy = !(pops == 3 && bp_left > 0);
          if (!rdy) bp_left--;
        end
        default: rdy = 1'b1;
      endcase
      chk("run.valid", 32'(valid), 1);
      chk("run.busy",  32'(busy),  1);
      chk("run.addr",  32'(addr),  32'(q[0]));
      chk("run.last",  32'(last),  32'(q.size() == 1));
      chk("run.done",  32'(done),  0);
      if (rdy) begin
        void'(q.pop_front());
        pops++;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    rdy   = 1'b1;

    if (abort_after > 0) begin
      // Reset coincides with a Start request; reset must win.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk_idle_outs("rst.mid");
      chk("rst.addr", 32'(addr), 0);
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
      chk("rst.stall", 32'(stall_cnt), 0);
`endif
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk_idle_outs("rst.after");
      return;
    end

    chk("win.timeout", 32'(q.size()), 0);
    chk("end.valid", 32'(valid), 0);
    chk("end.busy",  32'(busy),  0);
    chk("end.done",  32'(done),  1);
    chk("end.sumen", 32'(sum_en), 1);
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
    chk("end.stall", 32'(stall_cnt), 32'(stalls));
`endif
    @(negedge clk);
    chk_idle_outs("end.idle");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ll = '0; wid = '0; ks = '0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    chk("reset.addr", 32'(addr), 0);
`ifdef RAM_WINDOW_ADDR_GEN_STALL_CNT_EN
    chk("reset.stall", 32'(stall_cnt), 0);
`endif
    rst = 1'b0;

    run_window(5, 28, 3, 0, 0);      // 5,6,7,33,34,35,61,62,63
    run_window(1020, 28, 2, 0, 0);   // 1020,1021,24,25
    run_window(5, 28, 3, 2, 0);      // hold 33 for 4 cycles
    run_window(100, 7, 0, 0, 0);     // K=0
    run_window(200, 40, 7, 1, 0);    // Start pulses mid-window ignored
    run_window(int'($urandom_range(0, 1023)), 30, 3, 0, 4);
    run_window(300, 50, 3, 0, 0);    // full window after abort
    run_window(1023, 1023, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      run_window(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(1, 7)), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
